// File: rtl/mem_bus_unit.sv
// mem_bus_unit: LC-3 memory access stage.
//
// Holds MAR and MDR, loaded from the datapath bus, and runs timed SRAM read and
// write cycles. Read data returns through MDR. A one-cycle ready pulse R marks
// access completion for the control state machine.
//
// Ports:
//   Clk, Reset_n          clock and asynchronous active-low reset
//   bus_in                datapath bus value (gate multiplexer output)
//   LD_MAR, LD_MDR        register loads from bus_in, honoured only when idle
//   mem_start, mem_we     access request and type (1 = write), sampled when idle
//   mem_rdata             SRAM read data
//   MAR, MDR              address and data registers
//   mem_addr, mem_wdata   SRAM address / write data (copies of MAR / MDR)
//   mem_ce_n, mem_oe_n,   active-low SRAM strobes, decoded from registered state
//   mem_we_n
//   busy                  high whenever not idle
//   R                     one-cycle ready pulse in the DONE state
module mem_bus_unit #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [15:0] bus_in,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        mem_start,
    input  logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        busy,
    output logic        R
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    // Counter preload: the last ACCESS cycle is the one that sees cnt == 0.
    localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        unique case (state_q)
            StIdle: begin
                // Loads and a start in the same cycle are both taken; the
                // strobes only begin next cycle, so the access sees new values.
                if (LD_MAR) mar_d = bus_in;
                if (LD_MDR) mdr_d = bus_in;
                if (mem_start) begin
                    wr_d    = mem_we;
                    cnt_d   = CntInit;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!wr_q) mdr_d = mem_rdata;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        MAR       = mar_q;
        MDR       = mdr_q;
        mem_addr  = mar_q;
        mem_wdata = mdr_q;
        mem_ce_n  = (state_q != StAccess);
        mem_oe_n  = !((state_q == StAccess) && !wr_q);
        mem_we_n  = !((state_q == StAccess) && wr_q);
        busy      = (state_q != StIdle);
        R         = (state_q == StDone);
    end

endmodule

// File: tb/tb_mem_bus_unit.sv
// Testbench for mem_bus_unit: randomized accesses on a WAIT_CYCLES=2 instance
// checked by a scoreboard monitor, plus directed checks on a WAIT_CYCLES=1 instance.
module tb_mem_bus_unit;

    localparam int Wait = 2;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Main instance (WAIT_CYCLES = 2)
    logic        Reset_n;
    logic [15:0] bus_in;
    logic        LD_MAR, LD_MDR, mem_start, mem_we;
    logic [15:0] mem_rdata;
    logic [15:0] MAR, MDR, mem_addr, mem_wdata;
    logic        mem_ce_n, mem_oe_n, mem_we_n, busy, R;

    mem_bus_unit #(.WAIT_CYCLES(Wait)) u_dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .bus_in    (bus_in),
        .LD_MAR    (LD_MAR),
        .LD_MDR    (LD_MDR),
        .mem_start (mem_start),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .MAR       (MAR),
        .MDR       (MDR),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ce_n  (mem_ce_n),
        .mem_oe_n  (mem_oe_n),
        .mem_we_n  (mem_we_n),
        .busy      (busy),
        .R         (R)
    );

    // Minimum-wait instance (WAIT_CYCLES = 1)
    logic        b_Reset_n;
    logic [15:0] b_bus_in;
    logic        b_LD_MAR, b_LD_MDR, b_mem_start, b_mem_we;
    logic [15:0] b_mem_rdata;
    logic [15:0] b_MAR, b_MDR, b_mem_addr, b_mem_wdata;
    logic        b_mem_ce_n, b_mem_oe_n, b_mem_we_n, b_busy, b_R;

    mem_bus_unit #(.WAIT_CYCLES(1)) u_dut1 (
        .Clk       (Clk),
        .Reset_n   (b_Reset_n),
        .bus_in    (b_bus_in),
        .LD_MAR    (b_LD_MAR),
        .LD_MDR    (b_LD_MDR),
        .mem_start (b_mem_start),
        .mem_we    (b_mem_we),
        .mem_rdata (b_mem_rdata),
        .MAR       (b_MAR),
        .MDR       (b_MDR),
        .mem_addr  (b_mem_addr),
        .mem_wdata (b_mem_wdata),
        .mem_ce_n  (b_mem_ce_n),
        .mem_oe_n  (b_mem_oe_n),
        .mem_we_n  (b_mem_we_n),
        .busy      (b_busy),
        .R         (b_R)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;  // write data driven, or read data expected in MDR
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [15:0] mar_m = 16'h0000;
    logic [15:0] mdr_m = 16'h0000;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: checks every strobe cycle and every R pulse against the queue head.
    int strobe_cnt = 0;
    bit r_prev = 1'b0;
    always @(negedge Clk) begin
        if (!Reset_n || !mon_en) begin
            strobe_cnt = 0;
            r_prev     = 1'b0;
        end else begin
            if (r_prev) check("busy_after_R", {15'd0, busy}, 16'd0);
            if (!mem_ce_n) begin
                strobe_cnt++;
                if (sb.size() == 0) begin
                    report_fail("strobe_without_request");
                end else begin
                    check("mem_addr", mem_addr, sb[0].addr);
                    check("MAR_stable", MAR, sb[0].addr);
                    if (sb[0].wr) begin
                        check("we_n_write", {15'd0, mem_we_n}, 16'd0);
                        check("oe_n_write", {15'd0, mem_oe_n}, 16'd1);
                        check("mem_wdata", mem_wdata, sb[0].data);
                    end else begin
                        check("oe_n_read", {15'd0, mem_oe_n}, 16'd0);
                        check("we_n_read", {15'd0, mem_we_n}, 16'd1);
                    end
                end
            end
            if (R) begin
                if (sb.size() == 0) begin
                    report_fail("spurious_R");
                end else begin
                    check("strobe_cycles", 16'(strobe_cnt), 16'(Wait));
                    check("strobes_high_in_done", {13'd0, mem_ce_n, mem_oe_n, mem_we_n}, 16'h7);
                    if (!sb[0].wr) check("read_MDR", MDR, sb[0].data);
                    void'(sb.pop_front());
                end
                strobe_cnt = 0;
            end
            r_prev = R;
        end
    end

    task automatic idle_inputs();
        LD_MAR    = 1'b0;
        LD_MDR    = 1'b0;
        mem_start = 1'b0;
    endtask

    // Issue one idle-cycle operation and update the reference model.
    task automatic issue(input bit ldmar, input bit ldmdr, input logic [15:0] v,
                         input bit start, input bit wr, input logic [15:0] rdata);
        bus_in    = v;
        LD_MAR    = ldmar;
        LD_MDR    = ldmdr;
        mem_start = start;
        mem_we    = wr;
        mem_rdata = rdata;
        if (ldmar) mar_m = v;
        if (ldmdr) mdr_m = v;
        if (start) begin
            if (!wr) mdr_m = rdata;
            sb.push_back('{wr, mar_m, (wr ? mdr_m : rdata)});
        end
        tick();
        idle_inputs();
        if (!start) begin
            check("MAR_load", MAR, mar_m);
            check("mem_addr_load", mem_addr, mar_m);
            check("MDR_load", MDR, mdr_m);
            check("mem_wdata_load", mem_wdata, mdr_m);
        end
    endtask

    // While busy, throw random loads/starts at the DUT; all must be ignored.
    task automatic run_busy();
        int n = 0;
        while (busy && n < 20) begin
            bus_in    = 16'($urandom);
            LD_MAR    = 1'($urandom_range(0, 1));
            LD_MDR    = 1'($urandom_range(0, 1));
            mem_start = 1'($urandom_range(0, 1));
            mem_we    = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        idle_inputs();
        if (busy) report_fail("busy_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_MAR"}, MAR, 16'h0000);
        check({tag, "_MDR"}, MDR, 16'h0000);
        check({tag, "_R_busy"}, {14'd0, R, busy}, 16'd0);
        check({tag, "_strobes"}, {13'd0, mem_ce_n, mem_oe_n, mem_we_n}, 16'h7);
    endtask

    initial begin
        Reset_n   = 1'b0;
        bus_in    = 16'h0000;
        mem_we    = 1'b0;
        mem_rdata = 16'h0000;
        idle_inputs();
        b_Reset_n   = 1'b0;
        b_bus_in    = 16'h0000;
        b_LD_MAR    = 1'b0;
        b_LD_MDR    = 1'b0;
        b_mem_start = 1'b0;
        b_mem_we    = 1'b0;
        b_mem_rdata = 16'h0000;
        repeat (3) tick();
        check_reset_outputs("por");
        Reset_n   = 1'b1;
        b_Reset_n = 1'b1;
        mon_en    = 1'b1;
        tick();

        // Bus loads
        issue(1'b1, 1'b0, 16'h3000, 1'b0, 1'b0, 16'h0000);
        issue(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000);

        // Directed read, cycle by cycle (issue returns in cycle 1)
        issue(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234);
        check("rd_c1_strobes", {13'd0, mem_ce_n, mem_oe_n, mem_we_n}, 16'h1);
        tick();
        check("rd_c2_strobes", {13'd0, mem_ce_n, mem_oe_n, mem_we_n}, 16'h1);
        tick();
        check("rd_c3_R", {15'd0, R}, 16'd1);
        check("rd_c3_MDR", MDR, 16'h1234);
        tick();
        check("rd_c4_busy", {15'd0, busy}, 16'd0);

        // Write with simultaneous MDR load
        issue(1'b0, 1'b1, 16'h00FF, 1'b1, 1'b1, 16'hDEAD);
        run_busy();

        // Busy lockout
        issue(1'b1, 1'b0, 16'h4000, 1'b0, 1'b0, 16'h0000);
        issue(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hCAFE);
        bus_in    = 16'hFFFF;
        LD_MAR    = 1'b1;
        mem_start = 1'b1;
        tick();
        idle_inputs();
        run_busy();
        tick();
        check("lockout_MAR", MAR, 16'h4000);
        check("lockout_one_R", 16'(sb.size()), 16'd0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            logic [15:0] v;
            logic [15:0] rd;
            int          op;
            v  = 16'($urandom);
            rd = 16'($urandom);
            op = $urandom_range(0, 3);
            case (op)
                0: issue(1'b1, 1'b0, v, 1'b0, 1'b0, rd);
                1: issue(1'b0, 1'b1, v, 1'b0, 1'b0, rd);
                2: issue(1'($urandom_range(0, 1)), 1'b0, v, 1'b1, 1'b0, rd);
                default: issue(1'b0, 1'($urandom_range(0, 1)), v, 1'b1, 1'b1, rd);
            endcase
            run_busy();
        end
        tick();
        check("scoreboard_drained", 16'(sb.size()), 16'd0);

        // Reset in the middle of an access
        issue(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 16'h9999);
        #2;
        Reset_n = 1'b0;
        mon_en  = 1'b0;
        sb.delete();
        mar_m = 16'h0000;
        mdr_m = 16'h0000;
        #1;
        check_reset_outputs("midrun");
        tick();
        Reset_n = 1'b1;
        tick();
        check_reset_outputs("after_reset");
        mon_en = 1'b1;

        // WAIT_CYCLES = 1: single strobe cycle, R in cycle 2
        b_bus_in = 16'h0010;
        b_LD_MAR = 1'b1;
        tick();
        b_LD_MAR    = 1'b0;
        b_mem_rdata = 16'h5A5A;
        b_mem_we    = 1'b0;
        b_mem_start = 1'b1;
        tick();
        b_mem_start = 1'b0;
        check("w1_c1_strobes", {13'd0, b_mem_ce_n, b_mem_oe_n, b_mem_we_n}, 16'h1);
        check("w1_c1_R", {15'd0, b_R}, 16'd0);
        tick();
        check("w1_c2_R", {15'd0, b_R}, 16'd1);
        check("w1_c2_strobes", {13'd0, b_mem_ce_n, b_mem_oe_n, b_mem_we_n}, 16'h7);
        check("w1_c2_MDR", b_MDR, 16'h5A5A);
        tick();
        check("w1_c3_busy", {15'd0, b_busy}, 16'd0);

        // WAIT_CYCLES = 1: read aborted by reset during ACCESS
        b_mem_rdata = 16'h1111;
        b_mem_start = 1'b1;
        tick();
        b_mem_start = 1'b0;
        #2;
        b_Reset_n = 1'b0;
        #1;
        check("abort_MDR", b_MDR, 16'h0000);
        check("abort_R", {15'd0, b_R}, 16'd0);
        check("abort_strobes", {13'd0, b_mem_ce_n, b_mem_oe_n, b_mem_we_n}, 16'h7);
        tick();
        b_Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_R", {15'd0, b_R}, 16'd0);
            check("abort_MDR_hold", b_MDR, 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_unit.md
# mem_bus_unit

LC-3 memory access stage that sits directly downstream of the datapath bus multiplexers. It holds MAR and MDR, which are loaded from the 16-bit bus value selected by the gate multiplexer. It runs timed read and write cycles on the external SRAM strobes and returns the read data through MDR. A one-cycle ready pulse (`R`) tells the control state machine that an access has completed.

## Interface
- `WAIT_CYCLES`, default 2: number of cycles the SRAM strobes stay asserted per access; legal range 1–15.
- `Clk` input, 1 bit: rising-edge clock for all state.
- `Reset_n` input, 1 bit: reset, asynchronous and active-low.
- `bus_in` input, 16 bits: datapath bus value, taken from the gate multiplexer output.
- `LD_MAR` input, 1 bit: load MAR from `bus_in`.
- `LD_MDR` input, 1 bit: load MDR from `bus_in`; only honoured when the block is idle.
- `mem_start` input, 1 bit: start-of-access pulse; sampled only in IDLE.
- `mem_we` input, 1 bit: access type, sampled with `mem_start`; 1 = write, 0 = read.
- `mem_rdata` input, 16 bits: SRAM read data.
- `MAR` output, 16 bits: address register.
- `MDR` output, 16 bits: data register; feeds the GateMDR input of the bus multiplexer.
- `mem_addr` output, 16 bits: equals `MAR`.
- `mem_wdata` output, 16 bits: equals `MDR`.
- `mem_ce_n` output, 1 bit: SRAM chip enable, active-low.
- `mem_oe_n` output, 1 bit: SRAM output enable, active-low.
- `mem_we_n` output, 1 bit: SRAM write enable, active-low.
- `busy` output, 1 bit: high in every state except IDLE.
- `R` output, 1 bit: ready pulse, high for exactly one cycle, in DONE.

## Operation
- **States:** IDLE, ACCESS, DONE, plus a registered access-type flag `wr` and a down-counter `cnt` of 4 bits.
- **IDLE:**
  - `LD_MAR=1` loads `MAR<=bus_in`.
  - `LD_MDR=1` loads `MDR<=bus_in`.
  - `mem_start=1` latches `wr<=mem_we`, sets `cnt<=WAIT_CYCLES-1` and moves to ACCESS.
  - A load and `mem_start` in the same cycle are both honoured. The access then uses the newly loaded MAR/MDR, because the strobes begin on the following cycle.
- **ACCESS:**
  - `mem_ce_n=0` in every ACCESS cycle.
  - Read: `mem_oe_n=0`, `mem_we_n=1`.
  - Write: `mem_we_n=0`, `mem_oe_n=1`.
  - `cnt` decrements each cycle while `cnt!=0`.
  - When `cnt==0`: for a read, `MDR<=mem_rdata` at that edge; the state then moves to DONE.
- **DONE:**
  - All strobes are high and `R=1`.
  - Unconditionally returns to IDLE on the next edge.
- **Busy-state rules:**
  - `LD_MAR`, `LD_MDR` and `mem_start` are ignored in ACCESS and DONE.
  - MAR and MDR are stable from the first ACCESS cycle through DONE, apart from the read capture into MDR.
- **Output timing:** all strobes are decoded from registered state only, so they are glitch-free relative to `Clk`.

## Timing
- **Reset values** (applied asynchronously while `Reset_n=0`):
  - `MAR=0`, `MDR=0`, `wr=0`, `cnt=0`, state = IDLE.
  - `mem_ce_n=1`, `mem_oe_n=1`, `mem_we_n=1`, `busy=0`, `R=0`.
- **Latency:** `mem_start` is sampled at edge 0. ACCESS occupies cycles 1..WAIT_CYCLES. DONE, with `R=1`, is cycle WAIT_CYCLES+1. The next `mem_start` can be accepted in cycle WAIT_CYCLES+2.
- **Read data:** `mem_rdata` is sampled at the rising edge that ends the last ACCESS cycle. The new MDR is visible in the DONE cycle.
- **Register loads:** MAR and MDR loads from the bus take effect at the next edge, with zero cycles of added latency.
- **Reset mid-access:** strobes go high and `R` goes low immediately (asynchronously). Registers clear, and no partial MDR update occurs.
- **`WAIT_CYCLES=1`:** ACCESS lasts a single cycle, because `cnt` starts at 0.

## Test plan
- **Reset values:** assert `Reset_n=0` mid-run.
  - Required: `MAR`, `MDR`, `R` and `busy` are 0 and all strobes are 1 before the next `Clk` edge.
- **Bus loads:** `bus_in=16'h3000` with `LD_MAR=1`, then `bus_in=16'hBEEF` with `LD_MDR=1`, while IDLE.
  - Required: `MAR=3000`, `mem_addr=3000`, `MDR=BEEF`, `mem_wdata=BEEF` one cycle after each load.
- **Read:** `WAIT_CYCLES=2`, `MAR=3000`, `mem_rdata=16'h1234`, pulse `mem_start` with `mem_we=0`.
  - Required: `ce_n` and `oe_n` are low for exactly 2 cycles, and `we_n` stays high.
  - Required: `R=1` in cycle 3 with `MDR=1234`, and `busy` drops in cycle 4.
- **Write with simultaneous load:** `LD_MDR=1`, `bus_in=16'h00FF` and `mem_start=1` with `mem_we=1`, all in the same cycle.
  - Required: `mem_wdata=00FF` throughout the 2-cycle `we_n=0` window.
- **Busy lockout:** during ACCESS, pulse `LD_MAR` with `bus_in=16'hFFFF` and pulse `mem_start`.
  - Required: `MAR` is unchanged and exactly one `R` pulse occurs.
- **Minimum wait and abort:** with `WAIT_CYCLES=1`, run a read, then run a read that is reset during ACCESS.
  - First read: one strobe cycle, `R` in cycle 2.
  - Aborted read: `MDR=0` and no `R` pulse.
